// File: rtl/bandgap_ctrl_pkg.sv
// Shared types and defaults for the bandgap reference power sequencer.
// Optional irq output is enabled by defining BANDGAP_CTRL_IRQ_EN.
package bandgap_ctrl_pkg;

   typedef enum logic [1:0] {
      BG_OFF     = 2'b00,
      BG_STARTUP = 2'b01,
      BG_ON      = 2'b10,
      BG_HOLD    = 2'b11
   } bg_state_t;

   localparam int BG_CNT_W = 16;

   function automatic logic bg_en_of(input bg_state_t s);
      return s != BG_OFF;
   endfunction

   function automatic logic bg_ready_of(input bg_state_t s);
      return (s == BG_ON) || (s == BG_HOLD);
   endfunction

endpackage

// File: rtl/bandgap_ctrl_timer.sv
// Loadable down-counter shared by the settle and hold-off phases.
// Saturates at zero; only a load moves it off zero.
module bandgap_ctrl_timer
   import bandgap_ctrl_pkg::*;
#(
   parameter int CNT_W = BG_CNT_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/bandgap_ctrl.sv
// Bandgap EN sequencer and sharing arbiter with settle time and hold-off.
// Define BANDGAP_CTRL_IRQ_EN to add a ready-rise irq pulse output.
module bandgap_ctrl
   import bandgap_ctrl_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int STARTUP_CYCLES = 1000,
   parameter int HOLD_CYCLES    = 64,
   parameter int CNT_W          = BG_CNT_W
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [NREQ-1:0] req,
   input  logic            force_on,
   output logic            bg_en,
   output logic            bg_ready,
   output logic [NREQ-1:0] ack,
   output logic [1:0]      state
`ifdef BANDGAP_CTRL_IRQ_EN
   ,
   output logic            irq
`endif
);

   localparam logic [CNT_W-1:0] START_LD =
      CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD =
      (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
   localparam bit NO_HOLD = (HOLD_CYCLES == 0);

   bg_state_t        cur;
   bg_state_t        nxt;
   logic             any_req;
   logic             ld;
   logic [CNT_W-1:0] ld_val;
   logic             cnt_en;
   logic             zero;

   assign any_req = (|req) | force_on;

   bandgap_ctrl_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .resetn   (resetn),
      .load     (ld),
      .load_val (ld_val),
      .en       (cnt_en),
      .zero     (zero)
   );

   // Settling always runs to completion; only the exit target
   // depends on whether anyone still wants the reference.
   always_comb begin
      nxt    = cur;
      ld     = 1'b0;
      ld_val = START_LD;
      cnt_en = 1'b0;
      unique case (cur)
         BG_OFF: begin
            if (any_req) begin
               nxt    = BG_STARTUP;
               ld     = 1'b1;
               ld_val = START_LD;
            end
         end
         BG_STARTUP: begin
            if (!zero) begin
               cnt_en = 1'b1;
            end else if (any_req) begin
               nxt = BG_ON;
            end else if (NO_HOLD) begin
               nxt = BG_OFF;
            end else begin
               nxt    = BG_HOLD;
               ld     = 1'b1;
               ld_val = HOLD_LD;
            end
         end
         BG_ON: begin
            if (!any_req) begin
               if (NO_HOLD) begin
                  nxt = BG_OFF;
               end else begin
                  nxt    = BG_HOLD;
                  ld     = 1'b1;
                  ld_val = HOLD_LD;
               end
            end
         end
         BG_HOLD: begin
            if (any_req) begin
               nxt = BG_ON;
            end else if (zero) begin
               nxt = BG_OFF;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            nxt = BG_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cur      <= BG_OFF;
         bg_en    <= 1'b0;
         bg_ready <= 1'b0;
      end else begin
         cur      <= nxt;
         bg_en    <= bg_en_of(nxt);
         bg_ready <= bg_ready_of(nxt);
      end
   end

`ifdef BANDGAP_CTRL_IRQ_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         irq <= 1'b0;
      end else begin
         irq <= bg_ready_of(nxt) & ~bg_ready;
      end
   end
`endif

   assign ack   = req & {NREQ{bg_ready}};
   assign state = cur;

endmodule

// File: tb/tb_bandgap_ctrl.sv
// Directed bench for bandgap_ctrl with a cycle-level reference model.
// Build with BANDGAP_CTRL_IRQ_EN defined to also check irq.
module tb_bandgap_ctrl;

   localparam int S = 8;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] req;
   logic       force_on;
   logic       bg_en;
   logic       bg_ready;
   logic [3:0] ack;
   logic [1:0] state;
`ifdef BANDGAP_CTRL_IRQ_EN
   logic       irq;
`endif

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;

   bandgap_ctrl #(
      .NREQ           (4),
      .STARTUP_CYCLES (S),
      .HOLD_CYCLES    (H),
      .CNT_W          (16)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .req      (req),
      .force_on (force_on),
      .bg_en    (bg_en),
      .bg_ready (bg_ready),
      .ack      (ack),
      .state    (state)
`ifdef BANDGAP_CTRL_IRQ_EN
      ,
      .irq      (irq)
`endif
   );

   always #5 clk = ~clk;

   // en: reference powered; ready: settled; elapsed: edges since
   // power-up; idle: consecutive unrequested edges while settled.
   typedef struct {
      bit en;
      bit ready;
      int elapsed;
      int idle;
      bit irq;
   } mdl_t;

   mdl_t m = '{default: 0};

   function automatic mdl_t step(input mdl_t c, input bit any);
      mdl_t n;
      n = c;
      n.irq = 1'b0;
      if (!c.en) begin
         if (any) begin
            n.en = 1'b1;
            n.elapsed = 0;
         end
      end else if (!c.ready) begin
         n.elapsed = c.elapsed + 1;
         if (n.elapsed == S) begin
            n.ready = 1'b1;
            n.idle = any ? 0 : 1;
            if (n.idle > H) begin
               n.en = 1'b0;
               n.ready = 1'b0;
               n.idle = 0;
            end
            n.irq = n.ready;
         end
      end else if (any) begin
         n.idle = 0;
      end else begin
         n.idle = c.idle + 1;
         if (n.idle > H) begin
            n.en = 1'b0;
            n.ready = 1'b0;
            n.idle = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [1:0] state_of(input mdl_t c);
      if (!c.en) return 2'b00;
      if (!c.ready) return 2'b01;
      if (c.idle > 0) return 2'b11;
      return 2'b10;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) m <= '{default: 0};
      else m <= step(m, (|req) | force_on);
   end

   always @(negedge clk) begin
      if (chk_on) begin
         logic [1:0] es;
         logic [3:0] ea;
         bit bad;
         es = state_of(m);
         ea = req & {4{m.ready}};
         bad = (bg_en !== m.en) || (bg_ready !== m.ready) ||
               (ack !== ea) || (state !== es);
`ifdef BANDGAP_CTRL_IRQ_EN
         bad = bad || (irq !== m.irq);
`endif
         vectors++;
         if (bad) begin
            miscompares++;
            $display("FAIL model t=%0t en=%b/%b ready=%b/%b ack=%h/%h st=%b/%b (got/exp)",
                     $time, bg_en, m.en, bg_ready, m.ready, ack, ea, state, es);
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lit(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   initial begin
      resetn = 1'b1;
      req = '0;
      force_on = 1'b0;
      #2 resetn = 1'b0;
      #1 chk_on = 1'b1;
      cyc(3);
      lit("reset_state", {bg_en, bg_ready, ack, state}, 32'h0);
      resetn = 1'b1;

      // idle after reset
      cyc(20);
      lit("idle_state", {30'd0, state}, 32'h0);
      lit("idle_en", {31'd0, bg_en}, 32'h0);

      // single startup
      req = 4'b0001;
      cyc();
      lit("start_en", {31'd0, bg_en}, 32'h1);
      lit("start_state", {30'd0, state}, 32'h1);
      cyc(7);
      lit("edge7_ready", {31'd0, bg_ready}, 32'h0);
      lit("edge7_ack", {28'd0, ack}, 32'h0);
      cyc();
      lit("edge8_ready", {31'd0, bg_ready}, 32'h1);
      lit("edge8_ack", {28'd0, ack}, 32'h1);
      lit("edge8_state", {30'd0, state}, 32'h2);
`ifdef BANDGAP_CTRL_IRQ_EN
      lit("edge8_irq", {31'd0, irq}, 32'h1);
      cyc();
      lit("edge9_irq", {31'd0, irq}, 32'h0);
`endif

      // hold-off reuse
      req = 4'b0000;
      cyc();
      lit("hold_state", {30'd0, state}, 32'h3);
      cyc();
      req = 4'b0100;
      #1;
      lit("reuse_ack", {28'd0, ack}, 32'h4);
      cyc();
      lit("reuse_state", {30'd0, state}, 32'h2);
      lit("reuse_ready", {31'd0, bg_ready}, 32'h1);

      // hold expiry
      req = 4'b0000;
      cyc(4);
      lit("hold_last", {30'd0, state}, 32'h3);
      cyc();
      lit("expire_state", {30'd0, state}, 32'h0);
      lit("expire_en", {31'd0, bg_en}, 32'h0);

      // request on the expiry edge wins
      req = 4'b0001;
      cyc(9);
      lit("on_again", {30'd0, state}, 32'h2);
      req = 4'b0000;
      cyc(4);
      req = 4'b0010;
      cyc();
      lit("race_state", {30'd0, state}, 32'h2);
      lit("race_en", {31'd0, bg_en}, 32'h1);

      // drop during startup
      req = 4'b0000;
      cyc(5);
      lit("off_again", {30'd0, state}, 32'h0);
      req = 4'b1000;
      cyc(2);
      req = 4'b0000;
      cyc(6);
      lit("drop_edge7", {30'd0, state}, 32'h1);
      cyc();
      lit("drop_edge8", {30'd0, state}, 32'h3);
      lit("drop_ack", {28'd0, ack}, 32'h0);
      cyc(3);
      lit("drop_hold", {30'd0, state}, 32'h3);
      cyc();
      lit("drop_off", {30'd0, state}, 32'h0);

      // async reset mid-startup
      req = 4'b0001;
      cyc(6);
      #2 resetn = 1'b0;
      #1;
      lit("arst_en", {31'd0, bg_en}, 32'h0);
      lit("arst_state", {30'd0, state}, 32'h0);
      cyc();
      resetn = 1'b1;
      cyc(8);
      lit("arst_edge7", {31'd0, bg_ready}, 32'h0);
      cyc();
      lit("arst_edge8", {31'd0, bg_ready}, 32'h1);

      // force_on alone keeps the reference up
      req = 4'b0000;
      force_on = 1'b1;
      cyc(6);
      lit("force_state", {30'd0, state}, 32'h2);
      force_on = 1'b0;
      cyc(6);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
